// File: rtl/caliptra_sync_filter.sv
`default_nettype none
// ============================================================================
// Module      : caliptra_sync_filter
// Description : Multi-bit level synchronizer with per-channel stability
//               filter and registered rise/fall edge pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module caliptra_sync_filter #(
    parameter int                 WIDTH       = 1,
    parameter int                 STAGES      = 2,
    parameter int                 FILT_CYCLES = 1,
    parameter logic [WIDTH-1:0]   RESET_VAL   = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    // Counter must hold values 0..FILT_CYCLES-1; never narrower than one bit.
    localparam int c_cnt_w_raw = $clog2(FILT_CYCLES + 1);
    localparam int c_cnt_w     = (c_cnt_w_raw < 1) ? 1 : c_cnt_w_raw;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(FILT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    // Reject illegal configurations at elaboration.
    if (STAGES < 2) begin : g_bad_stages
        $error("caliptra_sync_filter: STAGES must be >= 2");
    end
    if (FILT_CYCLES < 1) begin : g_bad_filt
        $error("caliptra_sync_filter: FILT_CYCLES must be >= 1");
    end

    logic [STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]             w_synced;
    logic [WIDTH-1:0]             w_dout_next;
    logic [WIDTH-1:0]             r_dout;
    logic [WIDTH-1:0]             r_rise;
    logic [WIDTH-1:0]             r_fall;

    // Synchronizer chain: stage 0 captures din, each later stage shifts the previous one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {STAGES{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], din};
        end
    end

    assign w_synced = r_sync[STAGES-1];

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        logic [c_cnt_w-1:0] r_cnt;
        logic [c_cnt_w-1:0] w_cnt_next;
        logic               w_bit_next;

        // Stability filter: output follows synced only after FILT_CYCLES consecutive disagreements.
        always_comb begin
            w_cnt_next = '0;
            w_bit_next = r_dout[i];
            if (w_synced[i] != r_dout[i]) begin
                if (r_cnt == c_cnt_last) begin
                    w_bit_next = w_synced[i];
                end else begin
                    w_cnt_next = r_cnt + c_cnt_one;
                end
            end
        end

        // Per-channel filter counter; reset discards any partial count.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= w_cnt_next;
            end
        end

        assign w_dout_next[i] = w_bit_next;
    end

    // Filtered output and edge pulses, all registered from the same next value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout <= RESET_VAL;
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_dout <= w_dout_next;
            r_rise <= w_dout_next & ~r_dout;
            r_fall <= ~w_dout_next & r_dout;
        end
    end

    assign dout    = r_dout;
    assign rise    = r_rise;
    assign fall    = r_fall;
    assign changed = |(r_rise | r_fall);

endmodule
`default_nettype wire

// File: doc/caliptra_sync_filter.md
CALIPTRA_SYNC_FILTER -- requirements
Module: caliptra_sync_filter

Interface
REQ-001 SHALL have parameter WIDTH, default 1: number of independent single-bit channels.
REQ-002 SHALL have parameter STAGES, default 2: synchronizer flop count per channel; elaboration error if < 2.
REQ-003 SHALL have parameter FILT_CYCLES, default 1: consecutive stable cycles required before output update; 1 = no filtering; elaboration error if < 1.
REQ-004 SHALL have parameter RESET_VAL, WIDTH bits, default '0: reset value of synchronizer chain and dout.
REQ-005 SHALL have port clk  input  1  sole clock; all flops rise-edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port din  input  WIDTH  asynchronous or foreign-domain level inputs.
REQ-008 SHALL have port dout  output  WIDTH  synchronized, filtered level, registered.
REQ-009 SHALL have port rise  output  WIDTH  one-cycle pulse per bit on dout 0->1, registered.
REQ-010 SHALL have port fall  output  WIDTH  one-cycle pulse per bit on dout 1->0, registered.
REQ-011 SHALL have port changed  output  1  OR-reduction of rise|fall, combinational from registered rise/fall.

Function
REQ-012 Per channel, SHALL implement a STAGES-deep flop chain s[0..STAGES-1]; s[0] samples din, s[i] samples s[i-1]; synced = s[STAGES-1].
REQ-013 Per channel, SHALL hold a filter counter of width $clog2(FILT_CYCLES+1) (min 1 bit).
REQ-014 Each edge, synced == dout: counter <= 0, dout holds.
REQ-015 Each edge, synced != dout and counter == FILT_CYCLES-1: dout <= synced, counter <= 0.
REQ-016 Each edge, synced != dout and counter < FILT_CYCLES-1: counter <= counter+1, dout holds.
REQ-017 Synced pulse shorter than FILT_CYCLES cycles SHALL NOT change dout; counter SHALL return to 0 when synced matches dout again.
REQ-018 Latency: din stable from edge k onward (sampled at k) -> dout updated at edge k+STAGES+FILT_CYCLES-1.
REQ-019 rise[i] SHALL be 1 for exactly the cycle following the edge where dout[i] goes 0->1; fall[i] likewise for 1->0; otherwise 0.
REQ-020 rise[i] and fall[i] SHALL never be 1 simultaneously; channels SHALL be fully independent (simultaneous events on different bits each reported).
REQ-021 Counter SHALL never exceed FILT_CYCLES-1; no wrap-around.
REQ-022 No combinational path from din to any output.

Reset
REQ-023 While rst=1 at an edge: s[*] <= RESET_VAL, dout <= RESET_VAL, counters <= 0, rise <= 0, fall <= 0; rst SHALL override all other updates.
REQ-024 Reset asserted mid-filter SHALL discard partial count; no dout update or pulse results from pre-reset history.
REQ-025 After rst deasserts with din == RESET_VAL, no rise/fall pulse SHALL occur.

Verification (WIDTH=4, STAGES=2, FILT_CYCLES=3, RESET_VAL=4'h0 unless stated; edge 0 = first edge with rst=0)
REQ-026 Reset with din=4'hF held -> dout=0, rise=fall=0 during reset; dout=4'hF at edge 4, rise=4'hF for one cycle after edge 4, changed=1 same cycle.
REQ-027 Glitch: din[0]=1 sampled at 2 edges only -> dout stays 4'h0, rise=0, counter back to 0.
REQ-028 din[0]=1 sampled at exactly 3 edges then 0 -> dout[0] rises at edge k+4, falls 3 edges after synced returns low; one rise and one fall pulse.
REQ-029 dout=4'h4; same edge din[1] 0->1 and din[2] 1->0, held -> rise=4'h2 and fall=4'h4 in the same cycle, dout=4'h2.
REQ-030 din[3] 0->1, rst=1 for one edge when counter=2 -> no update; after release, dout[3]=1 only 4 edges after edge 0.
REQ-031 STAGES=3, FILT_CYCLES=1, RESET_VAL=4'hA, din=4'hA out of reset -> no pulses; din->4'h5 sampled at edge k -> dout=4'h5 at edge k+3, rise=4'h5, fall=4'hA.
